uart_cmd_ctrl: RTL
==================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate; DIV = CLK_HZ/BAUD (5208 at defaults), DIV >= 16.
REQ-003 SHALL have parameter TMO_BITS, default 20, inter-byte timeout in bit periods.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  in  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 SHALL have port cmd_ready  in  1  consumer accepts the held command.
REQ-008 SHALL have port cmd_valid  out  1  command available.
REQ-009 SHALL have port cmd_addr  out  4  register address (low nibble of address byte).
REQ-010 SHALL have port cmd_data  out  8  register data.
REQ-011 SHALL have port frame_err  out  1  one-cycle pulse, bad stop bit.
REQ-012 SHALL have port ovr  out  1  one-cycle pulse, byte dropped while command held.
REQ-013 SHALL have port busy  out  1  high whenever receiver is not IDLE or parser is not WAIT_HDR.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer initialised to 1; all decisions use the synchronized value.
REQ-015 SHALL run receiver FSM IDLE->START->DATA->STOP->IDLE; IDLE leaves on synced 1->0 edge.
REQ-016 SHALL in START resample after DIV/2 cycles; sample 1 = false start, return to IDLE, no pulse.
REQ-017 SHALL sample 8 data bits at DIV-cycle intervals after start midpoint, shifting LSB first, using a $clog2(DIV)-bit counter cleared on every sample.
REQ-018 SHALL sample stop DIV cycles after bit 7; 1 = byte strobe, 0 = frame_err pulse, byte discarded, parser to WAIT_HDR.
REQ-019 SHALL run parser FSM WAIT_HDR->WAIT_ADDR->WAIT_DATA->[WAIT_CSUM]->HOLD; WAIT_HDR advances only on byte 0xA5, others ignored.
REQ-020 SHALL assert cmd_valid the cycle after the final byte's stop sample, with cmd_addr/cmd_data stable until the handshake.
REQ-021 SHALL complete the handshake on a cycle with cmd_valid and cmd_ready both high; next cycle cmd_valid=0, parser WAIT_HDR.
REQ-022 SHALL in HOLD drop every received byte with a one-cycle ovr pulse; held command unchanged.
REQ-023 SHALL return the parser to WAIT_HDR if no byte strobe for TMO_BITS*DIV cycles in WAIT_ADDR/WAIT_DATA/WAIT_CSUM; no pulse.
REQ-024 SHALL, on a byte strobe coinciding with handshake, treat the byte as arriving in WAIT_HDR.

Reset
REQ-025 SHALL on reset set cmd_valid, cmd_addr, cmd_data, frame_err, ovr, busy to 0, synchronizer to 1, both FSMs to IDLE/WAIT_HDR, all counters 0; takes effect mid-frame next cycle.

Configuration
REQ-026 SHALL with UART_CMD_CHECKSUM_EN defined insert WAIT_CSUM: byte must equal addr_byte XOR data_byte, else one-cycle csum_err (out 1, reset 0) pulse and WAIT_HDR.
REQ-027 SHALL without UART_CMD_CHECKSUM_EN omit WAIT_CSUM and port csum_err; WAIT_DATA goes directly to HOLD.

Structure
REQ-028 SHALL place header constant 0xA5, receiver and parser state enums in shared package uart_cmd_pkg.
REQ-029 SHALL implement receiver (REQ-014..018) as sub-module uart_rx_core (byte strobe, byte, frame_err outputs).

Verification (defaults, DIV=5208)
REQ-030 SHALL send A5 03 7E (+7D if CHECKSUM_EN), cmd_ready=1 -> one-cycle cmd_valid, cmd_addr=3, cmd_data=0x7E.
REQ-031 SHALL send A5 then address byte with stop=0 -> one frame_err pulse, no cmd_valid; following good A5 05 11 (+14) accepted.
REQ-032 SHALL drive rx low for 1000 cycles while idle -> no byte strobe, no pulse, busy returns 0.
REQ-033 SHALL hold cmd_ready=0 after A5 02 33 (+31), send 0x44 -> ovr pulse, cmd_addr=2/cmd_data=0x33 unchanged until cmd_ready.
REQ-034 SHALL send A5 then idle 20*5208+1 cycles, then 01 02 -> no command (timeout), busy=0 before 01.
REQ-035 SHALL assert reset during bit 4 of a data byte -> all outputs 0 next cycle; next full frame received correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command controller: header byte,
// receiver and parser state encodings, checksum helper.
package uart_cmd_pkg;

  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  typedef logic [2:0] p_state_t;
  localparam p_state_t P_WAIT_HDR  = 3'd0;
  localparam p_state_t P_WAIT_ADDR = 3'd1;
  localparam p_state_t P_WAIT_DATA = 3'd2;
  localparam p_state_t P_WAIT_CSUM = 3'd3;
  localparam p_state_t P_HOLD      = 3'd4;

  function automatic logic csum_ok(
    input logic [7:0] a,
    input logic [7:0] d,
    input logic [7:0] c
  );
    return (a ^ d) == c;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-edge detect, mid-bit
// sampling; emits a byte strobe or a frame_err pulse per frame.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       strobe,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(DIV - 1);

  logic [1:0]    sync;
  logic          prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          rxs;

  assign rxs  = sync[1];
  assign busy = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      prev      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      data      <= '0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      prev      <= rxs;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (prev && !rxs)
            state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            bitn  <= '0;
            // line back high at mid-start: treat as a glitch
            state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_END) begin
            cnt  <= '0;
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7)
              state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_END) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxs) begin
              strobe <= 1'b1;
              data   <= sh;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: A5 <addr> <data> [csum] frames into a held
// command with valid/ready. Optional checksum via UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int TMO_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       frame_err,
  output logic       ovr,
  output logic       busy
`ifdef UART_CMD_CHECKSUM_EN
  ,
  output logic       csum_err
`endif
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TMO = TMO_BITS * DIV;
  localparam int TW  = $clog2(TMO + 1);
`ifdef UART_CMD_CHECKSUM_EN
  localparam int AW  = 8;
`else
  localparam int AW  = 4;
`endif

  logic          strobe;
  logic [7:0]    rx_byte;
  logic          rx_ferr;
  logic          rx_busy;

  p_state_t      pstate;
  logic [AW-1:0] addr_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    data_q;
`endif
  logic [TW-1:0] tcnt;
  logic          waiting;
  logic          hs;
  logic          is_hdr;

  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .strobe    (strobe),
    .data      (rx_byte),
    .frame_err (rx_ferr),
    .busy      (rx_busy)
  );

  assign frame_err = rx_ferr;
  assign cmd_valid = (pstate == P_HOLD);
  assign busy      = rx_busy || (pstate != P_WAIT_HDR);
  assign hs        = cmd_valid && cmd_ready;
  assign is_hdr    = strobe && (rx_byte == HDR);
  assign waiting   = (pstate == P_WAIT_ADDR) ||
                     (pstate == P_WAIT_DATA) ||
                     (pstate == P_WAIT_CSUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      pstate   <= P_WAIT_HDR;
      addr_q   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      data_q   <= '0;
      csum_err <= 1'b0;
`endif
      tcnt     <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      ovr      <= 1'b0;
    end else begin
      ovr <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_err <= 1'b0;
`endif
      if (!waiting || strobe)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      case (pstate)
        P_WAIT_HDR: begin
          if (is_hdr)
            pstate <= P_WAIT_ADDR;
        end
        P_WAIT_ADDR: begin
          if (strobe) begin
            addr_q <= rx_byte[AW-1:0];
            pstate <= P_WAIT_DATA;
          end
        end
        P_WAIT_DATA: begin
          if (strobe) begin
`ifdef UART_CMD_CHECKSUM_EN
            data_q <= rx_byte;
            pstate <= P_WAIT_CSUM;
`else
            cmd_addr <= addr_q[3:0];
            cmd_data <= rx_byte;
            pstate   <= P_HOLD;
`endif
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        P_WAIT_CSUM: begin
          if (strobe) begin
            if (csum_ok(addr_q, data_q, rx_byte)) begin
              cmd_addr <= addr_q[3:0];
              cmd_data <= data_q;
              pstate   <= P_HOLD;
            end else begin
              csum_err <= 1'b1;
              pstate   <= P_WAIT_HDR;
            end
          end
        end
`endif
        P_HOLD: begin
          // a byte landing on the handshake cycle is parsed as a header
          if (hs)
            pstate <= is_hdr ? P_WAIT_ADDR : P_WAIT_HDR;
          else if (strobe)
            ovr <= 1'b1;
        end
        default: pstate <= P_WAIT_HDR;
      endcase

      if (rx_ferr && pstate != P_HOLD)
        pstate <= P_WAIT_HDR;
      if (waiting && !strobe && tcnt == TW'(TMO - 1))
        pstate <= P_WAIT_HDR;
    end
  end

endmodule
